// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared tracker entry type, forwarding source code and slot indices
// for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // Tracker entries store destinations at this width; the controller's REG_AW must not exceed it.
    localparam int MAX_REG_AW      = 8;
    localparam int FWD_SRC_REGFILE = 0;
    localparam int SLOT_EX         = 0;
    localparam int SLOT_MEM        = 1;
    localparam int SLOT_WB         = 2;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] dest;
        logic                  is_load;
    } track_entry_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// Combinational youngest-writer search for one source operand across the
// comparable tracker slots (0..TRACK_DEPTH-2).
module hazard_match
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int TRACK_DEPTH = 3,
    parameter int FWD_W       = 2
) (
    input  track_entry_t      tracker [TRACK_DEPTH],
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    output logic              hit,
    output logic [FWD_W-1:0]  slot,
    output logic              is_load
);

    logic [TRACK_DEPTH-2:0] match;

    // The oldest slot is committing to the register file this edge, so it is never compared.
    generate
        for (genvar gi = 0; gi < TRACK_DEPTH - 1; gi++) begin : g_cmp
            assign match[gi] = used && (src != '0) && tracker[gi].valid &&
                               (tracker[gi].dest == MAX_REG_AW'(src));
        end
    endgenerate

    always_comb begin
        hit     = 1'b0;
        slot    = '0;
        is_load = 1'b0;
        // Scan oldest to youngest so the youngest match is the one that sticks.
        for (int j = TRACK_DEPTH - 2; j >= 0; j--) begin
            if (match[j]) begin
                hit     = 1'b1;
                slot    = FWD_W'(j);
                is_load = tracker[j].is_load;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller beside the ID stage: load-use stalls, bubbles, forwarding selects, redirect flushes.
// Optional StallCount/FlushCount outputs are enabled by defining PIPELINE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int TRACK_DEPTH     = 3,
    parameter int LOAD_READY_SLOT = 2,
    parameter int REDIRECT_SLOT   = 1,
    parameter int FWD_W           = $clog2(TRACK_DEPTH + 1)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     ID_Valid,
    input  logic [REG_AW-1:0]        ID_Rs,
    input  logic [REG_AW-1:0]        ID_Rt,
    input  logic                     ID_UsesRs,
    input  logic                     ID_UsesRt,
    input  logic [REG_AW-1:0]        ID_Dest,
    input  logic                     ID_RegWrite,
    input  logic                     ID_MemRead,
    input  logic                     Redirect,
    output logic                     Stall,
    output logic                     Bubble,
    output logic [FWD_W-1:0]         FwdSelA,
    output logic [FWD_W-1:0]         FwdSelB,
    output logic [REDIRECT_SLOT+1:0] FlushMask
`ifdef PIPELINE_HAZARD_PERF_EN
    ,
    output logic [31:0]              StallCount,
    output logic [31:0]              FlushCount
`endif
);

    track_entry_t     track_reg [TRACK_DEPTH];
    logic             hit_a, hit_b, load_a, load_b;
    logic [FWD_W-1:0] slot_a, slot_b;
    logic             late_a, late_b, load_use, advance;
    logic [FWD_W-1:0] fwd_a_reg, fwd_b_reg;

    hazard_match #(.REG_AW(REG_AW), .TRACK_DEPTH(TRACK_DEPTH), .FWD_W(FWD_W)) u_match_a (
        .tracker(track_reg), .src(ID_Rs), .used(ID_UsesRs & ID_Valid),
        .hit(hit_a), .slot(slot_a), .is_load(load_a)
    );

    hazard_match #(.REG_AW(REG_AW), .TRACK_DEPTH(TRACK_DEPTH), .FWD_W(FWD_W)) u_match_b (
        .tracker(track_reg), .src(ID_Rt), .used(ID_UsesRt & ID_Valid),
        .hit(hit_b), .slot(slot_b), .is_load(load_b)
    );

    // A load in slot j has its data forwardable once it reaches slot LOAD_READY_SLOT-1 or older.
    assign late_a    = hit_a && load_a && (int'(slot_a) + 1 < LOAD_READY_SLOT);
    assign late_b    = hit_b && load_b && (int'(slot_b) + 1 < LOAD_READY_SLOT);
    assign load_use  = ~Rst & (late_a | late_b);
    assign advance   = ID_Valid & ~load_use & ~Redirect;

    assign Stall     = load_use & ~Redirect;
    assign Bubble    = load_use | (Redirect & ~Rst);
    assign FlushMask = {(REDIRECT_SLOT + 2){Redirect & ~Rst}};
    assign FwdSelA   = fwd_a_reg;
    assign FwdSelB   = fwd_b_reg;

    // Redirect kills the wrong-path entries younger than the resolving slot before they shift.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < TRACK_DEPTH; i++) begin
                track_reg[i] <= '0;
            end
        end else begin
            if (advance && ID_RegWrite) begin
                track_reg[SLOT_EX] <= '{valid: 1'b1, dest: MAX_REG_AW'(ID_Dest), is_load: ID_MemRead};
            end else begin
                track_reg[SLOT_EX] <= '0;
            end
            for (int i = 1; i < TRACK_DEPTH; i++) begin
                track_reg[i] <= (Redirect && (i - 1 < REDIRECT_SLOT)) ? '0 : track_reg[i-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || Redirect) begin
            fwd_a_reg <= FWD_W'(FWD_SRC_REGFILE);
            fwd_b_reg <= FWD_W'(FWD_SRC_REGFILE);
        end else if (load_use) begin
            fwd_a_reg <= fwd_a_reg;
            fwd_b_reg <= fwd_b_reg;
        end else if (advance) begin
            fwd_a_reg <= hit_a ? slot_a + FWD_W'(1) : FWD_W'(FWD_SRC_REGFILE);
            fwd_b_reg <= hit_b ? slot_b + FWD_W'(1) : FWD_W'(FWD_SRC_REGFILE);
        end else begin
            fwd_a_reg <= FWD_W'(FWD_SRC_REGFILE);
            fwd_b_reg <= FWD_W'(FWD_SRC_REGFILE);
        end
    end

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [31:0] stall_count_reg, flush_count_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (Stall) stall_count_reg <= stall_count_reg + 32'd1;
            if (Redirect) flush_count_reg <= flush_count_reg + 32'd1;
        end
    end

    assign StallCount = stall_count_reg;
    assign FlushCount = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: default instance plus a TRACK_DEPTH=4/LOAD_READY_SLOT=3 instance,
// directed scenarios and random stimulus against an instruction-history reference model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_urs, id_urt, id_rw, id_mr, redirect;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       stall0, bubble0, stall1, bubble1;
    logic [2:0] flush0, flush1;
    logic [1:0] fa0, fb0;
    logic [2:0] fa1, fb1;
`ifdef PIPELINE_HAZARD_PERF_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif

    pipeline_hazard_ctrl dut0 (
        .Clk(clk), .Rst(rst), .ID_Valid(id_valid), .ID_Rs(id_rs), .ID_Rt(id_rt),
        .ID_UsesRs(id_urs), .ID_UsesRt(id_urt), .ID_Dest(id_dest), .ID_RegWrite(id_rw),
        .ID_MemRead(id_mr), .Redirect(redirect), .Stall(stall0), .Bubble(bubble0),
        .FwdSelA(fa0), .FwdSelB(fb0), .FlushMask(flush0)
`ifdef PIPELINE_HAZARD_PERF_EN
        , .StallCount(sc0), .FlushCount(fc0)
`endif
    );

    pipeline_hazard_ctrl #(.TRACK_DEPTH(4), .LOAD_READY_SLOT(3)) dut1 (
        .Clk(clk), .Rst(rst), .ID_Valid(id_valid), .ID_Rs(id_rs), .ID_Rt(id_rt),
        .ID_UsesRs(id_urs), .ID_UsesRt(id_urt), .ID_Dest(id_dest), .ID_RegWrite(id_rw),
        .ID_MemRead(id_mr), .Redirect(redirect), .Stall(stall1), .Bubble(bubble1),
        .FwdSelA(fa1), .FwdSelB(fb1), .FlushMask(flush1)
`ifdef PIPELINE_HAZARD_PERF_EN
        , .StallCount(sc1), .FlushCount(fc1)
`endif
    );

    logic       obs_stall [2], obs_bubble [2];
    logic [2:0] obs_flush [2], obs_fa [2], obs_fb [2];
    assign obs_stall[0]  = stall0;        assign obs_stall[1]  = stall1;
    assign obs_bubble[0] = bubble0;       assign obs_bubble[1] = bubble1;
    assign obs_flush[0]  = flush0;        assign obs_flush[1]  = flush1;
    assign obs_fa[0]     = {1'b0, fa0};   assign obs_fa[1]     = fa1;
    assign obs_fb[0]     = {1'b0, fb0};   assign obs_fb[1]     = fb1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a history of what entered EX on each edge, looked up by age.
    int         td  [2] = '{3, 4};
    int         lrs [2] = '{2, 3};
    int         rsl [2] = '{1, 1};
    bit         h_w    [2][1024];
    logic [4:0] h_dest [2][1024];
    bit         h_ld   [2][1024];
    int         t = 1024;
    logic [2:0] m_fa [2] = '{3'd0, 3'd0};
    logic [2:0] m_fb [2] = '{3'd0, 3'd0};
    logic [31:0] m_sc [2] = '{32'd0, 32'd0};
    logic [31:0] m_fc [2] = '{32'd0, 32'd0};
    bit         m_lu [2];
    int         m_ja [2], m_jb [2];
    bit         exp_stall [2], exp_bubble [2];
    logic [2:0] exp_flush [2];

    task automatic youngest(input int c, input logic [4:0] src, input logic used,
                            output int j, output bit ld);
        j  = -1;
        ld = 1'b0;
        if (used && src != 5'd0) begin
            for (int k = td[c] - 2; k >= 0; k--) begin
                if (h_w[c][(t - 1 - k) & 1023] && h_dest[c][(t - 1 - k) & 1023] == src) begin
                    j  = k;
                    ld = h_ld[c][(t - 1 - k) & 1023];
                end
            end
        end
    endtask

    task automatic model_comb();
        for (int c = 0; c < 2; c++) begin
            int ja, jb;
            bit la, lb;
            youngest(c, id_rs, id_valid && id_urs, ja, la);
            youngest(c, id_rt, id_valid && id_urt, jb, lb);
            m_ja[c] = ja;
            m_jb[c] = jb;
            m_lu[c] = !rst && ((ja >= 0 && la && ja + 1 < lrs[c]) || (jb >= 0 && lb && jb + 1 < lrs[c]));
            exp_stall[c]  = m_lu[c] && !redirect;
            exp_bubble[c] = m_lu[c] || (redirect && !rst);
            exp_flush[c]  = (redirect && !rst) ? 3'b111 : 3'b000;
        end
    endtask

    task automatic model_edge();
        model_comb();
        for (int c = 0; c < 2; c++) begin
            bit adv;
            adv = id_valid && !m_lu[c] && !redirect;
            if (rst) begin
                for (int k = 0; k < 1024; k++) h_w[c][k] = 1'b0;
                m_fa[c] = 3'd0; m_fb[c] = 3'd0; m_sc[c] = 32'd0; m_fc[c] = 32'd0;
            end else begin
                if (exp_stall[c]) m_sc[c] = m_sc[c] + 32'd1;
                if (redirect) m_fc[c] = m_fc[c] + 32'd1;
                if (redirect) begin
                    m_fa[c] = 3'd0; m_fb[c] = 3'd0;
                end else if (!m_lu[c]) begin
                    m_fa[c] = (adv && m_ja[c] >= 0) ? 3'(m_ja[c] + 1) : 3'd0;
                    m_fb[c] = (adv && m_jb[c] >= 0) ? 3'(m_jb[c] + 1) : 3'd0;
                end
                if (redirect) begin
                    for (int k = 0; k < rsl[c]; k++) h_w[c][(t - 1 - k) & 1023] = 1'b0;
                end
                h_w[c][t & 1023]    = adv && id_rw;
                h_dest[c][t & 1023] = id_dest;
                h_ld[c][t & 1023]   = id_mr;
            end
        end
        t++;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] dst, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_urs = urs; id_urt = urt;
        id_dest = dst; id_rw = rw; id_mr = mr;
    endtask

    task automatic eval();
        @(negedge clk);
        model_comb();
    endtask

    task automatic tick(input string tag);
        $display("%-10s t=%0d v=%0b rs=%0d rt=%0d dst=%0d rw=%0b ld=%0b redir=%0b rst=%0b | stall=%0b/%0b bub=%0b/%0b fa=%0d/%0d fb=%0d/%0d",
                 tag, t, id_valid, id_rs, id_rt, id_dest, id_rw, id_mr, redirect, rst,
                 stall0, stall1, bubble0, bubble1, fa0, fa1, fb0, fb1);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        redirect = 1'b0;
        for (int i = 0; i < n; i++) begin
            eval();
            tick("idle");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        eval(); tick("reset");
        eval(); tick("reset");
        rst = 1'b0;
        eval();
        n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall0); end
        n_checks++; if (bubble0 !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %0b want 0", bubble0); end
        n_checks++; if (flush0 !== 3'b000) begin n_fail++; $display("FAIL reset_flush got %b want 000", flush0); end
        n_checks++; if (fa0 !== 2'd0 || fb0 !== 2'd0) begin n_fail++; $display("FAIL reset_fwd got %0d/%0d want 0/0", fa0, fb0); end
        n_checks++; if (fa1 !== 3'd0 || stall1 !== 1'b0) begin n_fail++; $display("FAIL reset_dut1 got fa=%0d stall=%0b want 0/0", fa1, stall1); end
        tick("idle");
    endtask

    task automatic test_alu_forward();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        eval(); tick("add");
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        eval();
        n_checks++; if (stall0 !== 1'b0 || stall1 !== 1'b0) begin n_fail++; $display("FAIL alu_nostall got %0b/%0b want 0/0", stall0, stall1); end
        tick("sub");
        idle_cycles(0);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        eval();
        n_checks++; if (fa0 !== 2'd1 || fb0 !== 2'd0) begin n_fail++; $display("FAIL alu_fwd got %0d/%0d want 1/0", fa0, fb0); end
        n_checks++; if (fa1 !== 3'd1) begin n_fail++; $display("FAIL alu_fwd_dut1 got %0d want 1", fa1); end
        tick("idle");
    endtask

    task automatic test_fwd_slot2();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        eval(); tick("add");
        set_id(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        eval(); tick("and");
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        eval();
        n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL slot2_nostall got %0b want 0", stall0); end
        tick("or");
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        eval();
        n_checks++; if (fa0 !== 2'd2 || fb0 !== 2'd0) begin n_fail++; $display("FAIL slot2_fwd got %0d/%0d want 2/0", fa0, fb0); end
        n_checks++; if (fa1 !== 3'd2) begin n_fail++; $display("FAIL slot2_fwd_dut1 got %0d want 2", fa1); end
        tick("idle");
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        eval(); tick("lw");
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        eval();
        n_checks++; if (stall0 !== 1'b1 || bubble0 !== 1'b1) begin n_fail++; $display("FAIL lu_stall1 got %0b/%0b want 1/1", stall0, bubble0); end
        n_checks++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL lu_deep_stall1 got %0b want 1", stall1); end
        tick("add");
        eval();
        n_checks++; if (stall0 !== 1'b0 || bubble0 !== 1'b0) begin n_fail++; $display("FAIL lu_release got %0b/%0b want 0/0", stall0, bubble0); end
        n_checks++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL lu_deep_stall2 got %0b want 1", stall1); end
        tick("add");
        eval();
        n_checks++; if (fa0 !== 2'd2 || fb0 !== 2'd2) begin n_fail++; $display("FAIL lu_fwd got %0d/%0d want 2/2", fa0, fb0); end
        n_checks++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL lu_deep_release got %0b want 0", stall1); end
        tick("add");
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        eval();
        n_checks++; if (fa1 !== 3'd3 || fb1 !== 3'd3) begin n_fail++; $display("FAIL lu_deep_fwd got %0d/%0d want 3/3", fa1, fb1); end
        tick("idle");
    endtask

    task automatic test_redirect_stall();
        set_id(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        eval(); tick("lw");
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        redirect = 1'b1;
        eval();
        n_checks++; if (stall0 !== 1'b0 || bubble0 !== 1'b1) begin n_fail++; $display("FAIL redir_stall got %0b/%0b want 0/1", stall0, bubble0); end
        n_checks++; if (flush0 !== 3'b111 || flush1 !== 3'b111) begin n_fail++; $display("FAIL redir_flush got %b/%b want 111/111", flush0, flush1); end
        n_checks++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL redir_stall_dut1 got %0b want 0", stall1); end
        tick("add+redir");
        redirect = 1'b0;
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        eval();
        n_checks++; if (stall0 !== 1'b0 || stall1 !== 1'b0 || flush0 !== 3'b000) begin n_fail++; $display("FAIL redir_after got stall=%0b/%0b flush=%b want 0/0/000", stall0, stall1, flush0); end
        tick("or");
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        eval();
        n_checks++; if (fa0 !== 2'd0 || fb0 !== 2'd0 || fa1 !== 3'd0) begin n_fail++; $display("FAIL redir_fwd got %0d/%0d/%0d want 0/0/0", fa0, fb0, fa1); end
        tick("idle");
    endtask

    task automatic test_zero_reg();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        eval(); tick("add_r0");
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        eval(); tick("lw_r0");
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        eval();
        n_checks++; if (stall0 !== 1'b0 || stall1 !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %0b/%0b want 0/0", stall0, stall1); end
        tick("rd_r0");
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        eval();
        n_checks++; if (fa0 !== 2'd0 || fb0 !== 2'd0) begin n_fail++; $display("FAIL r0_fwd got %0d/%0d want 0/0", fa0, fb0); end
        tick("idle");
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        eval(); tick("lw");
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        eval();
        n_checks++; if (stall0 !== 1'b1 || stall1 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall got %0b/%0b want 1/1", stall0, stall1); end
        rst = 1'b1;
        tick("rst");
        rst = 1'b0;
        eval();
        n_checks++; if (stall0 !== 1'b0 || stall1 !== 1'b0) begin n_fail++; $display("FAIL rst_post_stall got %0b/%0b want 0/0", stall0, stall1); end
        n_checks++; if (fa0 !== 2'd0 || fb0 !== 2'd0) begin n_fail++; $display("FAIL rst_post_fwd got %0d/%0d want 0/0", fa0, fb0); end
        tick("add");
        idle_cycles(3);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        eval(); tick("add");
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        eval();
        n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL cold_nostall got %0b want 0", stall0); end
        tick("sub");
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        eval();
        n_checks++; if (fa0 !== 2'd1 || fb0 !== 2'd0) begin n_fail++; $display("FAIL cold_fwd got %0d/%0d want 1/0", fa0, fb0); end
        tick("idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic rw;
            rw = ($urandom_range(0, 9) < 7);
            set_id(($urandom_range(0, 99) < 85), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 5)), rw,
                   rw && ($urandom_range(0, 9) < 4));
            redirect = ($urandom_range(0, 99) < 10);
            rst      = ($urandom_range(0, 99) < 2);
            eval();
            for (int c = 0; c < 2; c++) begin
                n_checks++; if (obs_stall[c] !== exp_stall[c]) begin n_fail++; $display("FAIL rand_stall cfg%0d t=%0d got %0b want %0b", c, t, obs_stall[c], exp_stall[c]); end
                n_checks++; if (obs_bubble[c] !== exp_bubble[c]) begin n_fail++; $display("FAIL rand_bubble cfg%0d t=%0d got %0b want %0b", c, t, obs_bubble[c], exp_bubble[c]); end
                n_checks++; if (obs_flush[c] !== exp_flush[c]) begin n_fail++; $display("FAIL rand_flush cfg%0d t=%0d got %b want %b", c, t, obs_flush[c], exp_flush[c]); end
                n_checks++; if (obs_fa[c] !== m_fa[c]) begin n_fail++; $display("FAIL rand_fwda cfg%0d t=%0d got %0d want %0d", c, t, obs_fa[c], m_fa[c]); end
                n_checks++; if (obs_fb[c] !== m_fb[c]) begin n_fail++; $display("FAIL rand_fwdb cfg%0d t=%0d got %0d want %0d", c, t, obs_fb[c], m_fb[c]); end
            end
            tick("rand");
        end
        rst = 1'b0;
        redirect = 1'b0;
`ifdef PIPELINE_HAZARD_PERF_EN
        eval();
        n_checks++; if (sc0 !== m_sc[0] || fc0 !== m_fc[0]) begin n_fail++; $display("FAIL perf_cfg0 got %0d/%0d want %0d/%0d", sc0, fc0, m_sc[0], m_fc[0]); end
        n_checks++; if (sc1 !== m_sc[1] || fc1 !== m_fc[1]) begin n_fail++; $display("FAIL perf_cfg1 got %0d/%0d want %0d/%0d", sc1, fc1, m_sc[1], m_fc[1]); end
        tick("perf");
`endif
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        idle_cycles(4);
        test_alu_forward();
        idle_cycles(4);
        test_fwd_slot2();
        idle_cycles(4);
        test_load_use();
        idle_cycles(4);
        test_redirect_stall();
        idle_cycles(4);
        test_zero_reg();
        idle_cycles(4);
        test_reset_mid_stall();
        idle_cycles(4);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
